// File: rtl/ram_ctrl_pkg.sv
// Shared types and constants for the byte-wide RAM word access controller.
package ram_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WR,
    RD,
    RSP
  } state_t;

  localparam int         BEATS          = 4;
  localparam int         DEFAULT_ADDR_W = 11;
  localparam logic [1:0] LAST_BEAT      = 2'(BEATS - 1);

  // Little-endian byte lane idx of a 32-bit word.
  function automatic logic [7:0] word_byte(input logic [31:0] word, input logic [1:0] idx);
    return word[{idx, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/ram_rr_arb.sv
// Two-way round-robin arbiter; remembers the last grant so ties alternate.
module ram_rr_arb (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  logic last_q;

  // Grant the sole requester, or on contention the one not served last.
  always_comb begin
    grant = 2'b00;
    if (req[0] && (!req[1] || last_q)) begin
      grant = 2'b01;
    end else if (req[1]) begin
      grant = 2'b10;
    end
  end

  // Track the last winner; after reset m1 counts as last so m0 wins a tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= 1'b1;
    end else if (advance && (grant != 2'b00)) begin
      last_q <= grant[1];
    end
  end

endmodule

// File: rtl/ram_word_ctrl.sv
// Word access controller: two requesters share a byte-wide RAM, each 32-bit
// access is split into four little-endian byte beats.
module ram_word_ctrl
  import ram_ctrl_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_m0_req,
  input  logic              i_m0_we,
  input  logic [ADDR_W-1:0] i_m0_addr,
  input  logic [31:0]       i_m0_wdata,
  input  logic [3:0]        i_m0_be,
  input  logic              i_m1_req,
  input  logic              i_m1_we,
  input  logic [ADDR_W-1:0] i_m1_addr,
  input  logic [31:0]       i_m1_wdata,
  input  logic [3:0]        i_m1_be,
  output logic              o_m0_gnt,
  output logic              o_m1_gnt,
  output logic              o_m0_rvalid,
  output logic              o_m1_rvalid,
  output logic [31:0]       o_m0_rdata,
  output logic [31:0]       o_m1_rdata,
  output logic              o_ram_we,
  output logic [ADDR_W-1:0] o_ram_waddr,
  output logic [ADDR_W-1:0] o_ram_raddr,
  output logic [7:0]        o_ram_wdata,
  input  logic [7:0]        i_ram_rdata
);

  localparam int WORD_W = ADDR_W - 2;

  state_t             state_q, state_d;
  logic [1:0]         beat_q, beat_d, beat_nxt;
  logic               id_q, id_d;
  logic [WORD_W-1:0]  word_q, word_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [3:0]         be_q, be_d;
  logic [23:0]        rbuf_q, rbuf_d;
  logic               ram_we_q, ram_we_d;
  logic [ADDR_W-1:0]  waddr_q, waddr_d, raddr_q, raddr_d;
  logic [7:0]         ram_wdata_q, ram_wdata_d;
  logic [1:0]         gnt_q, gnt_d, rvalid_q, rvalid_d;
  logic [31:0]        m0_rdata_q, m0_rdata_d, m1_rdata_q, m1_rdata_d;
  logic [1:0]         arb_req, arb_grant;
  logic               arb_advance;
  logic               sel_we;
  logic [WORD_W-1:0]  sel_word;
  logic [31:0]        sel_wdata;
  logic [3:0]         sel_be;
  logic               unused_addr_lsbs;

  assign arb_req          = {i_m1_req, i_m0_req};
  assign beat_nxt         = beat_q + 2'd1;
  assign unused_addr_lsbs = ^{i_m0_addr[1:0], i_m1_addr[1:0]};

  ram_rr_arb u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (arb_req),
    .advance (arb_advance),
    .grant   (arb_grant)
  );

  // Steer the winning requester's fields toward the latch registers.
  always_comb begin
    sel_we    = i_m0_we;
    sel_word  = i_m0_addr[ADDR_W-1:2];
    sel_wdata = i_m0_wdata;
    sel_be    = i_m0_be;
    if (arb_grant[1]) begin
      sel_we    = i_m1_we;
      sel_word  = i_m1_addr[ADDR_W-1:2];
      sel_wdata = i_m1_wdata;
      sel_be    = i_m1_be;
    end
  end

  // Next-state logic; RAM-side outputs are precomputed one beat ahead so they are registered.
  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    id_d        = id_q;
    word_d      = word_q;
    wdata_d     = wdata_q;
    be_d        = be_q;
    rbuf_d      = rbuf_q;
    ram_we_d    = 1'b0;
    waddr_d     = waddr_q;
    raddr_d     = raddr_q;
    ram_wdata_d = ram_wdata_q;
    gnt_d       = 2'b00;
    rvalid_d    = 2'b00;
    m0_rdata_d  = m0_rdata_q;
    m1_rdata_d  = m1_rdata_q;
    arb_advance = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (|arb_req) begin
          arb_advance = 1'b1;
          gnt_d       = arb_grant;
          id_d        = arb_grant[1];
          word_d      = sel_word;
          wdata_d     = sel_wdata;
          be_d        = sel_be;
          beat_d      = 2'd0;
          if (sel_we) begin
            state_d     = WR;
            waddr_d     = {sel_word, 2'd0};
            ram_wdata_d = word_byte(sel_wdata, 2'd0);
            ram_we_d    = sel_be[0];
          end else begin
            state_d = RD;
            raddr_d = {sel_word, 2'd0};
          end
        end
      end
      WR: begin
        if (beat_q == LAST_BEAT) begin
          state_d = IDLE;
        end else begin
          beat_d      = beat_nxt;
          waddr_d     = {word_q, beat_nxt};
          ram_wdata_d = word_byte(wdata_q, beat_nxt);
          ram_we_d    = be_q[beat_nxt];
        end
      end
      RD: begin
        if (beat_q != 2'd0) begin
          rbuf_d = {i_ram_rdata, rbuf_q[23:8]};
        end
        if (beat_q == LAST_BEAT) begin
          state_d = RSP;
        end else begin
          beat_d  = beat_nxt;
          raddr_d = {word_q, beat_nxt};
        end
      end
      RSP: begin
        state_d = IDLE;
        if (id_q) begin
          rvalid_d   = 2'b10;
          m1_rdata_d = {i_ram_rdata, rbuf_q};
        end else begin
          rvalid_d   = 2'b01;
          m0_rdata_d = {i_ram_rdata, rbuf_q};
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset aborts any transaction in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      beat_q      <= 2'd0;
      id_q        <= 1'b0;
      word_q      <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      rbuf_q      <= '0;
      ram_we_q    <= 1'b0;
      waddr_q     <= '0;
      raddr_q     <= '0;
      ram_wdata_q <= '0;
      gnt_q       <= 2'b00;
      rvalid_q    <= 2'b00;
      m0_rdata_q  <= '0;
      m1_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      id_q        <= id_d;
      word_q      <= word_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
      rbuf_q      <= rbuf_d;
      ram_we_q    <= ram_we_d;
      waddr_q     <= waddr_d;
      raddr_q     <= raddr_d;
      ram_wdata_q <= ram_wdata_d;
      gnt_q       <= gnt_d;
      rvalid_q    <= rvalid_d;
      m0_rdata_q  <= m0_rdata_d;
      m1_rdata_q  <= m1_rdata_d;
    end
  end

  assign o_m0_gnt    = gnt_q[0];
  assign o_m1_gnt    = gnt_q[1];
  assign o_m0_rvalid = rvalid_q[0];
  assign o_m1_rvalid = rvalid_q[1];
  assign o_m0_rdata  = m0_rdata_q;
  assign o_m1_rdata  = m1_rdata_q;
  assign o_ram_we    = ram_we_q & ~rst;
  assign o_ram_waddr = waddr_q;
  assign o_ram_raddr = raddr_q;
  assign o_ram_wdata = ram_wdata_q;

endmodule

// File: tb/tb_ram_word_ctrl.sv
// Self-checking bench for ram_word_ctrl with a behavioural byte RAM and a
// reference byte array for expected read data.
module tb_ram_word_ctrl;

  localparam int AW = 11;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_m0_req, i_m0_we, i_m1_req, i_m1_we;
  logic [AW-1:0] i_m0_addr, i_m1_addr;
  logic [31:0]   i_m0_wdata, i_m1_wdata;
  logic [3:0]    i_m0_be, i_m1_be;
  logic          o_m0_gnt, o_m1_gnt, o_m0_rvalid, o_m1_rvalid;
  logic [31:0]   o_m0_rdata, o_m1_rdata;
  logic          o_ram_we;
  logic [AW-1:0] o_ram_waddr, o_ram_raddr;
  logic [7:0]    o_ram_wdata;
  logic [7:0]    ram_rdata;

  logic [7:0]    mem  [0:2047];
  logic [7:0]    gold [0:2047];
  logic [AW-1:0] we_log [$];
  logic [31:0]   exp0_q [$];
  logic [31:0]   exp1_q [$];
  int            tests_run = 0;
  int            tests_failed = 0;

  ram_word_ctrl #(.ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .i_m0_req(i_m0_req), .i_m0_we(i_m0_we), .i_m0_addr(i_m0_addr),
    .i_m0_wdata(i_m0_wdata), .i_m0_be(i_m0_be),
    .i_m1_req(i_m1_req), .i_m1_we(i_m1_we), .i_m1_addr(i_m1_addr),
    .i_m1_wdata(i_m1_wdata), .i_m1_be(i_m1_be),
    .o_m0_gnt(o_m0_gnt), .o_m1_gnt(o_m1_gnt),
    .o_m0_rvalid(o_m0_rvalid), .o_m1_rvalid(o_m1_rvalid),
    .o_m0_rdata(o_m0_rdata), .o_m1_rdata(o_m1_rdata),
    .o_ram_we(o_ram_we), .o_ram_waddr(o_ram_waddr), .o_ram_raddr(o_ram_raddr),
    .o_ram_wdata(o_ram_wdata), .i_ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  // Byte RAM with one write port and a registered read port.
  always @(posedge clk) begin
    if (o_ram_we) mem[o_ram_waddr] <= o_ram_wdata;
    ram_rdata <= mem[o_ram_raddr];
  end

  // Log every RAM byte write address.
  always @(negedge clk) begin
    if (o_ram_we) we_log.push_back(o_ram_waddr);
  end

  function automatic logic [31:0] gold_word(input logic [AW-1:0] a);
    return {gold[{a[AW-1:2], 2'd3}], gold[{a[AW-1:2], 2'd2}],
            gold[{a[AW-1:2], 2'd1}], gold[{a[AW-1:2], 2'd0}]};
  endfunction

  task automatic gold_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] be);
    for (int k = 0; k < 4; k++) begin
      if (be[k]) gold[{a[AW-1:2], 2'(k)}] = d[8*k +: 8];
    end
  endtask

  task automatic set_req(input bit id, input logic we, input logic [AW-1:0] a,
                         input logic [31:0] d, input logic [3:0] be);
    if (id) begin
      i_m1_req = 1'b1; i_m1_we = we; i_m1_addr = a; i_m1_wdata = d; i_m1_be = be;
    end else begin
      i_m0_req = 1'b1; i_m0_we = we; i_m0_addr = a; i_m0_wdata = d; i_m0_be = be;
    end
  endtask

  task automatic clear_req(input bit id);
    if (id) i_m1_req = 1'b0;
    else    i_m0_req = 1'b0;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    i_m0_req = 1'b0; i_m0_we = 1'b0; i_m0_addr = '0; i_m0_wdata = '0; i_m0_be = '0;
    i_m1_req = 1'b0; i_m1_we = 1'b0; i_m1_addr = '0; i_m1_wdata = '0; i_m1_be = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  // Issue a write, wait for its grant, then wait until the controller is idle again.
  task automatic do_write(input bit id, input logic [AW-1:0] a, input logic [31:0] d,
                          input logic [3:0] be, output int gnt_lat);
    set_req(id, 1'b1, a, d, be);
    gold_write(a, d, be);
    gnt_lat = -1;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (id ? o_m1_gnt : o_m0_gnt) begin
        gnt_lat = n;
        break;
      end
    end
    clear_req(id);
    tests_run++;
    if (gnt_lat < 0) begin
      tests_failed++;
      $display("[TB] FAIL write_gnt_timeout: got no grant, required a grant for addr %h", a);
    end else begin
      repeat (4) @(negedge clk);
    end
  endtask

  // Issue a read; the scoreboard entry is popped and compared when rvalid shows up.
  task automatic do_read(input bit id, input logic [AW-1:0] a, output int gnt_lat,
                         output int rv_lat, output logic [4*AW-1:0] raddrs,
                         output logic [31:0] rdata);
    logic [31:0] exp;
    set_req(id, 1'b0, a, 32'h0, 4'h0);
    if (id) exp1_q.push_back(gold_word(a));
    else    exp0_q.push_back(gold_word(a));
    gnt_lat = -1; rv_lat = -1; raddrs = '0; rdata = '0;
    for (int n = 1; n <= 20 && rv_lat < 0; n++) begin
      @(negedge clk);
      if (gnt_lat < 0 && (id ? o_m1_gnt : o_m0_gnt)) begin
        gnt_lat = n;
        clear_req(id);
      end
      if (gnt_lat > 0 && n - gnt_lat < 4) raddrs[(n - gnt_lat)*AW +: AW] = o_ram_raddr;
      if (id ? o_m1_rvalid : o_m0_rvalid) begin
        rv_lat = n;
        rdata  = id ? o_m1_rdata : o_m0_rdata;
        exp    = id ? exp1_q.pop_front() : exp0_q.pop_front();
        tests_run++;
        if (rdata !== exp) begin
          tests_failed++;
          $display("[TB] FAIL sb_rdata m%0d addr %h: got %h expected %h", id, a, rdata, exp);
        end
      end
    end
    clear_req(id);
    tests_run++;
    if (rv_lat < 0) begin
      tests_failed++;
      $display("[TB] FAIL read_timeout m%0d addr %h: got no rvalid, required one", id, a);
    end
  endtask

  task automatic test_reset();
    logic [98:0] obs;
    apply_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    obs = {o_m0_gnt, o_m1_gnt, o_m0_rvalid, o_m1_rvalid, o_m0_rdata, o_m1_rdata,
           o_ram_we, o_ram_waddr, o_ram_raddr, o_ram_wdata};
    tests_run++;
    if (obs !== 99'd0) begin
      tests_failed++;
      $display("[TB] FAIL reset_outputs: got %h expected 0", obs);
    end
    rst = 1'b0;
    @(negedge clk);
    obs = {o_m0_gnt, o_m1_gnt, o_m0_rvalid, o_m1_rvalid, o_m0_rdata, o_m1_rdata,
           o_ram_we, o_ram_waddr, o_ram_raddr, o_ram_wdata};
    tests_run++;
    if (obs !== 99'd0) begin
      tests_failed++;
      $display("[TB] FAIL idle_outputs: got %h expected 0", obs);
    end
  endtask

  task automatic test_write_read();
    int g, rv;
    logic [4*AW-1:0] ra;
    logic [31:0] rd;
    do_write(1'b0, 11'h010, 32'hDEADBEEF, 4'hF, g);
    tests_run++;
    if (g != 1) begin
      tests_failed++;
      $display("[TB] FAIL wr_gnt_latency: got %0d expected 1", g);
    end
    tests_run++;
    if ({mem[11'h013], mem[11'h012], mem[11'h011], mem[11'h010]} !== 32'hDEADBEEF) begin
      tests_failed++;
      $display("[TB] FAIL ram_bytes_010: got %h expected deadbeef",
               {mem[11'h013], mem[11'h012], mem[11'h011], mem[11'h010]});
    end
    do_read(1'b0, 11'h010, g, rv, ra, rd);
    tests_run++;
    if (rv != 6 || rd !== 32'hDEADBEEF) begin
      tests_failed++;
      $display("[TB] FAIL rd_latency_data: got lat %0d data %h expected lat 6 data deadbeef", rv, rd);
    end
    @(negedge clk);
    tests_run++;
    if (o_m0_rvalid !== 1'b0 || o_m0_rdata !== 32'hDEADBEEF) begin
      tests_failed++;
      $display("[TB] FAIL rvalid_pulse_hold: got rvalid %b data %h expected 0 deadbeef",
               o_m0_rvalid, o_m0_rdata);
    end
  endtask

  task automatic test_byte_enable();
    int g, rv, n0;
    logic [4*AW-1:0] ra;
    logic [31:0] rd;
    do_write(1'b0, 11'h020, 32'h11223344, 4'hF, g);
    n0 = we_log.size();
    do_write(1'b0, 11'h020, 32'hAABBCCDD, 4'b0101, g);
    tests_run++;
    if (we_log.size() - n0 != 2) begin
      tests_failed++;
      $display("[TB] FAIL be_write_count: got %0d expected 2", we_log.size() - n0);
    end else if (we_log[n0] !== 11'h020 || we_log[n0+1] !== 11'h022) begin
      tests_failed++;
      $display("[TB] FAIL be_write_addrs: got %h %h expected 020 022", we_log[n0], we_log[n0+1]);
    end
    do_read(1'b0, 11'h020, g, rv, ra, rd);
    tests_run++;
    if (rd !== 32'h11BB33DD) begin
      tests_failed++;
      $display("[TB] FAIL be_merge: got %h expected 11bb33dd", rd);
    end
    n0 = we_log.size();
    do_write(1'b0, 11'h021, 32'hFFFFFFFF, 4'b0000, g);
    tests_run++;
    if (g != 1 || we_log.size() != n0) begin
      tests_failed++;
      $display("[TB] FAIL be_zero: got gnt_lat %0d writes %0d expected 1 and 0", g, we_log.size() - n0);
    end
    do_read(1'b0, 11'h020, g, rv, ra, rd);
    tests_run++;
    if (rd !== 32'h11BB33DD) begin
      tests_failed++;
      $display("[TB] FAIL be_zero_data: got %h expected 11bb33dd", rd);
    end
  endtask

  task automatic test_top_word();
    int g, rv;
    logic [4*AW-1:0] ra;
    logic [31:0] rd;
    do_write(1'b1, 11'h7FD, 32'h89ABCDEF, 4'hF, g);
    do_read(1'b1, 11'h7FE, g, rv, ra, rd);
    tests_run++;
    if (ra !== {11'h7FF, 11'h7FE, 11'h7FD, 11'h7FC}) begin
      tests_failed++;
      $display("[TB] FAIL top_raddr_seq: got %h expected 7ff 7fe 7fd 7fc packed", ra);
    end
    tests_run++;
    if (rd !== 32'h89ABCDEF) begin
      tests_failed++;
      $display("[TB] FAIL top_word_data: got %h expected 89abcdef", rd);
    end
    tests_run++;
    if (o_m0_rdata !== 32'h11BB33DD) begin
      tests_failed++;
      $display("[TB] FAIL m0_rdata_hold: got %h expected 11bb33dd", o_m0_rdata);
    end
  endtask

  task automatic test_reset_mid_write();
    int g, rv, n0;
    logic [4*AW-1:0] ra;
    logic [31:0] rd;
    bit saw_pulse;
    do_write(1'b0, 11'h040, 32'h55667788, 4'hF, g);
    n0 = we_log.size();
    set_req(1'b0, 1'b1, 11'h040, 32'hCAFEF00D, 4'hF);
    g = -1;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (o_m0_gnt) begin
        g = n;
        break;
      end
    end
    clear_req(1'b0);
    tests_run++;
    if (g != 1) begin
      tests_failed++;
      $display("[TB] FAIL abort_wr_gnt: got %0d expected 1", g);
    end
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    tests_run++;
    if (o_ram_we !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL we_gated_by_rst: got %b expected 0", o_ram_we);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    saw_pulse = o_m0_gnt | o_m1_gnt | o_m0_rvalid | o_m1_rvalid | o_ram_we;
    tests_run++;
    if (saw_pulse) begin
      tests_failed++;
      $display("[TB] FAIL abort_quiet: got a gnt/rvalid/we pulse expected none");
    end
    gold[11'h040] = 8'h0D;
    do_read(1'b0, 11'h040, g, rv, ra, rd);
    tests_run++;
    if (g != 1 || rd !== 32'h5566770D) begin
      tests_failed++;
      $display("[TB] FAIL abort_readback: got gnt_lat %0d data %h expected 1 5566770d", g, rd);
    end
    tests_run++;
    if (we_log.size() - n0 != 1 || we_log[n0] !== 11'h040) begin
      tests_failed++;
      $display("[TB] FAIL abort_write_log: got %0d writes expected exactly one to 040", we_log.size() - n0);
    end
  endtask

  task automatic test_back_to_back();
    int first, second, rv;
    logic [31:0] exp;
    set_req(1'b0, 1'b1, 11'h060, 32'h0BADCAFE, 4'hF);
    gold_write(11'h060, 32'h0BADCAFE, 4'hF);
    exp0_q.push_back(gold_word(11'h060));
    first = -1; second = -1; rv = -1;
    for (int n = 1; n <= 30 && rv < 0; n++) begin
      @(negedge clk);
      if (o_m0_gnt && first < 0) begin
        first = n;
        i_m0_we = 1'b0;
      end else if (o_m0_gnt) begin
        second = n;
        clear_req(1'b0);
      end
      if (o_m0_rvalid) begin
        rv  = n;
        exp = exp0_q.pop_front();
        tests_run++;
        if (o_m0_rdata !== exp || o_m0_rdata !== 32'h0BADCAFE) begin
          tests_failed++;
          $display("[TB] FAIL b2b_data: got %h expected %h", o_m0_rdata, exp);
        end
      end
    end
    clear_req(1'b0);
    tests_run++;
    if (first != 1 || second != 6 || rv != 11) begin
      tests_failed++;
      $display("[TB] FAIL b2b_timing: got gnt %0d/%0d rvalid %0d expected 1/6 11", first, second, rv);
    end
  endtask

  task automatic test_arbitration();
    logic [AW-1:0] m0_addrs [2];
    int order [$];
    int m0_idx, rv_seen;
    bit m0_reraise;
    logic [31:0] exp;
    apply_reset();
    m0_addrs[0] = 11'h010;
    m0_addrs[1] = 11'h040;
    m0_idx = 0; rv_seen = 0; m0_reraise = 1'b0;
    set_req(1'b0, 1'b0, m0_addrs[0], 32'h0, 4'h0);
    exp0_q.push_back(gold_word(m0_addrs[0]));
    set_req(1'b1, 1'b0, 11'h022, 32'h0, 4'h0);
    exp1_q.push_back(gold_word(11'h022));
    for (int n = 0; n < 100 && rv_seen < 3; n++) begin
      @(negedge clk);
      if (o_m0_gnt && o_m1_gnt) begin
        tests_run++;
        tests_failed++;
        $display("[TB] FAIL dual_grant: got both grants expected one");
      end
      if (o_m0_gnt) begin
        order.push_back(0);
        clear_req(1'b0);
        m0_idx++;
        m0_reraise = (m0_idx < 2);
      end else if (m0_reraise) begin
        set_req(1'b0, 1'b0, m0_addrs[m0_idx], 32'h0, 4'h0);
        exp0_q.push_back(gold_word(m0_addrs[m0_idx]));
        m0_reraise = 1'b0;
      end
      if (o_m1_gnt) begin
        order.push_back(1);
        clear_req(1'b1);
      end
      if (o_m0_rvalid) begin
        rv_seen++;
        exp = (exp0_q.size() > 0) ? exp0_q.pop_front() : 32'hxxxxxxxx;
        tests_run++;
        if (o_m0_rdata !== exp) begin
          tests_failed++;
          $display("[TB] FAIL arb_m0_rdata: got %h expected %h", o_m0_rdata, exp);
        end
      end
      if (o_m1_rvalid) begin
        rv_seen++;
        exp = (exp1_q.size() > 0) ? exp1_q.pop_front() : 32'hxxxxxxxx;
        tests_run++;
        if (o_m1_rdata !== exp) begin
          tests_failed++;
          $display("[TB] FAIL arb_m1_rdata: got %h expected %h", o_m1_rdata, exp);
        end
      end
    end
    clear_req(1'b0);
    clear_req(1'b1);
    tests_run++;
    if (rv_seen != 3) begin
      tests_failed++;
      $display("[TB] FAIL arb_completion: got %0d responses expected 3", rv_seen);
    end
    tests_run++;
    if (order.size() != 3) begin
      tests_failed++;
      $display("[TB] FAIL arb_grant_count: got %0d expected 3", order.size());
    end else if (order[0] != 0 || order[1] != 1 || order[2] != 0) begin
      tests_failed++;
      $display("[TB] FAIL arb_order: got m%0d m%0d m%0d expected m0 m1 m0", order[0], order[1], order[2]);
    end
  endtask

  initial begin
    apply_reset();
    test_reset();
    test_write_read();
    test_byte_enable();
    test_top_word();
    test_reset_mid_write();
    test_back_to_back();
    test_arbitration();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
